// File: rtl/cf_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package cf_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, TWAIT, IWAIT} cf_state_e;
  typedef enum logic [1:0] {FWD_NONE, FWD_E, FWD_M, FWD_W} fwd_sel_e;

  localparam int unsigned REG_ZERO = 0;

  // Per-stage control bundle, F in the MSB down to W in the LSB.
  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_ctl_t;
endpackage

// File: rtl/cf_fwd_match.sv
// One decode source operand: priority match against E > M > W destinations.
module cf_fwd_match
  import cf_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             src_vld_i,
  input  logic [REG_W-1:0] e_dest_i,
  input  logic [REG_W-1:0] m_dest_i,
  input  logic [REG_W-1:0] w_dest_i,
  input  logic             e_wren_i,
  input  logic             m_wren_i,
  input  logic             w_wren_i,
  output fwd_sel_e         sel_o,
  output logic             e_hit_o
);
  logic live;

  assign live    = src_vld_i && (src_i != REG_W'(REG_ZERO));
  assign e_hit_o = live && e_wren_i && (src_i == e_dest_i);

  always_comb begin
    sel_o = FWD_NONE;
    if (e_hit_o)                                      sel_o = FWD_E;
    else if (live && m_wren_i && (src_i == m_dest_i)) sel_o = FWD_M;
    else if (live && w_wren_i && (src_i == w_dest_i)) sel_o = FWD_W;
  end
endmodule

// File: rtl/control_flow_fwd.sv
// 5-stage hazard controller: forwarding select, load-use bubble, cache/TPU
// wait states, branch squash across I-cache misses, stall perf counter.
module control_flow_fwd
  import cf_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int NUM_SRC     = 2,
  parameter int CNT_W       = 16,
  parameter int TPU_TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_SRC*REG_W-1:0] d_src_reg_i,
  input  logic [NUM_SRC-1:0]       d_src_vld_i,
  input  logic [REG_W-1:0]         e_dest_reg_i,
  input  logic [REG_W-1:0]         m_dest_reg_i,
  input  logic [REG_W-1:0]         w_dest_reg_i,
  input  logic                     e_wren_i,
  input  logic                     m_wren_i,
  input  logic                     w_wren_i,
  input  logic                     e_is_load_i,
  input  logic                     branch_taken_i,
  input  logic                     icache_stall_i,
  input  logic                     dcache_stall_i,
  input  logic                     tpu_busy_i,
  output logic                     f_stall_o,
  output logic                     d_stall_o,
  output logic                     e_stall_o,
  output logic                     m_stall_o,
  output logic                     w_stall_o,
  output logic                     f_flush_o,
  output logic                     d_flush_o,
  output logic                     e_flush_o,
  output logic                     m_flush_o,
  output logic                     w_flush_o,
  output logic [NUM_SRC*2-1:0]     fwd_sel_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic                     tpu_timeout_o
);
  localparam int BW = $clog2(TPU_TIMEOUT + 1);

  cf_state_e               state_q, state_d;
  logic                    squash_q, squash_d;
  logic [BW-1:0]           busy_q, busy_d;
  logic                    tmo_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_SRC-1:0][1:0] fwd_q, fwd_nxt;
  logic [NUM_SRC-1:0]      e_hit;
  logic                    load_use, tpu_act, run_eval, any_stall;
  stage_ctl_t              stl, fls;
  logic [4:0]              stall_v, flush_v;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_sel_e sel;
    cf_fwd_match #(.REG_W(REG_W)) u_match (
      .src_i     (d_src_reg_i[k*REG_W +: REG_W]),
      .src_vld_i (d_src_vld_i[k]),
      .e_dest_i  (e_dest_reg_i),
      .m_dest_i  (m_dest_reg_i),
      .w_dest_i  (w_dest_reg_i),
      .e_wren_i  (e_wren_i),
      .m_wren_i  (m_wren_i),
      .w_wren_i  (w_wren_i),
      .sel_o     (sel),
      .e_hit_o   (e_hit[k])
    );
    assign fwd_nxt[k] = sel;
  end

  assign load_use = e_is_load_i & (|e_hit);

  always_comb begin
    stl      = '0;
    fls      = '0;
    state_d  = state_q;
    squash_d = squash_q;
    tpu_act  = 1'b0;
    run_eval = 1'b0;
    unique case (state_q)
      RUN:   run_eval = 1'b1;
      DWAIT: if (dcache_stall_i) stl = '1;
             else state_d = RUN;
      TWAIT: if (dcache_stall_i) begin
               stl = '1; state_d = DWAIT;
             end else if (tpu_busy_i) begin
               stl.f = 1'b1; stl.d = 1'b1; stl.e = 1'b1; fls.m = 1'b1; tpu_act = 1'b1;
             end else state_d = RUN;
      IWAIT: if (dcache_stall_i) begin
               stl = '1; state_d = DWAIT;
             end else if (tpu_busy_i) begin
               stl.f = 1'b1; stl.d = 1'b1; stl.e = 1'b1; fls.m = 1'b1;
               tpu_act = 1'b1; state_d = TWAIT;
             end else if (icache_stall_i) begin
               stl.f = 1'b1; fls.d = 1'b1;
               if (branch_taken_i) begin
                 fls.e = 1'b1; squash_d = 1'b1;
               end
             end else begin
               // Fill returned: a pending squash discards the wrong-path word.
               fls.d    = squash_q;
               squash_d = 1'b0;
               run_eval = 1'b1;
             end
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      state_d = RUN;
      if (dcache_stall_i) begin
        stl = '1; state_d = DWAIT;
      end else if (tpu_busy_i) begin
        stl.f = 1'b1; stl.d = 1'b1; stl.e = 1'b1; fls.m = 1'b1;
        tpu_act = 1'b1; state_d = TWAIT;
      end else if (branch_taken_i) begin
        fls.d = 1'b1; fls.e = 1'b1;
        if (icache_stall_i) begin
          stl.f = 1'b1; squash_d = 1'b1; state_d = IWAIT;
        end
      end else if (load_use) begin
        stl.f = 1'b1; stl.d = 1'b1; fls.e = 1'b1;
      end else if (icache_stall_i) begin
        stl.f = 1'b1; fls.d = 1'b1; state_d = IWAIT;
      end
    end
  end

  // Flush dominates stall; reset forces every control low immediately.
  assign flush_v   = {5{rst_n_i}} & fls;
  assign stall_v   = {5{rst_n_i}} & stl & ~fls;
  assign any_stall = |stall_v;

  assign {f_stall_o, d_stall_o, e_stall_o, m_stall_o, w_stall_o} = stall_v;
  assign {f_flush_o, d_flush_o, e_flush_o, m_flush_o, w_flush_o} = flush_v;

  assign busy_d = !tpu_act ? '0 :
                  (busy_q == BW'(TPU_TIMEOUT)) ? busy_q : busy_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RUN;
      squash_q <= 1'b0;
      busy_q   <= '0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
      fwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      busy_q   <= busy_d;
      if (tpu_act && (busy_q >= BW'(TPU_TIMEOUT - 1))) tmo_q <= 1'b1;
      if (any_stall && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      if (e_flush_o)       fwd_q <= '0;
      else if (!d_stall_o) fwd_q <= fwd_nxt;
    end
  end

  assign fwd_sel_o     = fwd_q;
  assign stall_cnt_o   = cnt_q;
  assign tpu_timeout_o = tmo_q;
endmodule

// File: tb/tb_control_flow_fwd.sv
// Bench for control_flow_fwd: rule-level model checked every cycle on two
// instances (default and CNT_W=4/TPU_TIMEOUT=8), plus directed literal checks.
module tb_control_flow_fwd;
  localparam int M_RUN = 0, M_D = 1, M_T = 2, M_I = 3;

  logic       clk, rst_n;
  logic [9:0] src;
  logic [1:0] vld;
  logic [4:0] e_dest, m_dest, w_dest;
  logic       e_wren, m_wren, w_wren, e_load, br, ic, dc, tp;

  wire [4:0]  a_st, a_fl, b_st, b_fl;
  wire [3:0]  a_fwd, b_fwd;
  wire [15:0] a_cnt;
  wire [3:0]  b_cnt;
  wire        a_tmo, b_tmo;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  control_flow_fwd u_a (
    .clk_i(clk), .rst_n_i(rst_n), .d_src_reg_i(src), .d_src_vld_i(vld),
    .e_dest_reg_i(e_dest), .m_dest_reg_i(m_dest), .w_dest_reg_i(w_dest),
    .e_wren_i(e_wren), .m_wren_i(m_wren), .w_wren_i(w_wren), .e_is_load_i(e_load),
    .branch_taken_i(br), .icache_stall_i(ic), .dcache_stall_i(dc), .tpu_busy_i(tp),
    .f_stall_o(a_st[4]), .d_stall_o(a_st[3]), .e_stall_o(a_st[2]), .m_stall_o(a_st[1]), .w_stall_o(a_st[0]),
    .f_flush_o(a_fl[4]), .d_flush_o(a_fl[3]), .e_flush_o(a_fl[2]), .m_flush_o(a_fl[1]), .w_flush_o(a_fl[0]),
    .fwd_sel_o(a_fwd), .stall_cnt_o(a_cnt), .tpu_timeout_o(a_tmo)
  );

  control_flow_fwd #(.CNT_W(4), .TPU_TIMEOUT(8)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .d_src_reg_i(src), .d_src_vld_i(vld),
    .e_dest_reg_i(e_dest), .m_dest_reg_i(m_dest), .w_dest_reg_i(w_dest),
    .e_wren_i(e_wren), .m_wren_i(m_wren), .w_wren_i(w_wren), .e_is_load_i(e_load),
    .branch_taken_i(br), .icache_stall_i(ic), .dcache_stall_i(dc), .tpu_busy_i(tp),
    .f_stall_o(b_st[4]), .d_stall_o(b_st[3]), .e_stall_o(b_st[2]), .m_stall_o(b_st[1]), .w_stall_o(b_st[0]),
    .f_flush_o(b_fl[4]), .d_flush_o(b_fl[3]), .e_flush_o(b_fl[2]), .m_flush_o(b_fl[1]), .w_flush_o(b_fl[0]),
    .fwd_sel_o(b_fwd), .stall_cnt_o(b_cnt), .tpu_timeout_o(b_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // Forwarding code a source must receive, straight from the E > M > W rule.
  function automatic int fwd_of(input int k);
    logic [4:0] s;
    s = src[k*5 +: 5];
    if (!vld[k] || s == 5'd0) return 0;
    if (e_wren && s == e_dest) return 1;
    if (m_wren && s == m_dest) return 2;
    if (w_wren && s == w_dest) return 3;
    return 0;
  endfunction

  // What the core is waiting on decides this cycle's controls; stall bits F..W = [4:0].
  function automatic void model_comb(input int mode, input bit sq,
                                     output logic [4:0] st, output logic [4:0] fl,
                                     output int nm, output bit nsq, output bit tc);
    bit lu;
    st = '0; fl = '0; nm = mode; nsq = sq; tc = 1'b0;
    lu = e_load && (fwd_of(0) == 1 || fwd_of(1) == 1);
    if (dc) begin
      st = 5'b11111; nm = M_D;
    end else if (mode == M_D) nm = M_RUN;
    else if (mode == M_T && !tp) nm = M_RUN;
    else if (tp) begin
      st = 5'b11100; fl = 5'b00010; tc = 1'b1; nm = M_T;
    end else if (mode == M_I && ic) begin
      st = 5'b10000; fl = 5'b01000;
      if (br) begin fl[2] = 1'b1; nsq = 1'b1; end
    end else begin
      nm = M_RUN;
      if (mode == M_I) begin
        if (sq) fl[3] = 1'b1;
        nsq = 1'b0;
      end
      if (br) begin
        fl[3] = 1'b1; fl[2] = 1'b1;
        if (ic) begin st[4] = 1'b1; nsq = 1'b1; nm = M_I; end
      end else if (lu) begin
        st[4] = 1'b1; st[3] = 1'b1; fl[2] = 1'b1;
      end else if (ic) begin
        st[4] = 1'b1; fl[3] = 1'b1; nm = M_I;
      end
    end
    st = st & ~fl;
  endfunction

  int         m_mode, n_mode, m_busy;
  bit         m_sq, n_sq, n_tc, m_tmo_a, m_tmo_b;
  logic [4:0] c_st, c_fl;
  logic [15:0] m_cnt_a;
  logic [3:0] m_cnt_b, m_fwd, n_fwd;

  always_comb begin
    c_st = '0; c_fl = '0; n_mode = M_RUN; n_sq = 1'b0; n_tc = 1'b0;
    model_comb(m_mode, m_sq, c_st, c_fl, n_mode, n_sq, n_tc);
    if (!rst_n) begin c_st = '0; c_fl = '0; end
    n_fwd = {2'(fwd_of(1)), 2'(fwd_of(0))};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_RUN; m_sq <= 1'b0; m_busy <= 0; m_tmo_a <= 1'b0; m_tmo_b <= 1'b0;
      m_cnt_a <= '0; m_cnt_b <= '0; m_fwd <= '0;
    end else begin
      m_mode <= n_mode;
      m_sq   <= n_sq;
      m_busy <= n_tc ? m_busy + 1 : 0;
      if (n_tc && m_busy + 1 >= 1024) m_tmo_a <= 1'b1;
      if (n_tc && m_busy + 1 >= 8)    m_tmo_b <= 1'b1;
      if ((|c_st) && m_cnt_a != 16'hFFFF) m_cnt_a <= m_cnt_a + 16'd1;
      if ((|c_st) && m_cnt_b != 4'hF)     m_cnt_b <= m_cnt_b + 4'd1;
      if (c_fl[2])     m_fwd <= '0;
      else if (!c_st[3]) m_fwd <= n_fwd;
    end
  end

  always @(negedge clk) begin
    chk("a_stall", 32'(a_st), 32'(c_st));
    chk("a_flush", 32'(a_fl), 32'(c_fl));
    chk("b_stall", 32'(b_st), 32'(c_st));
    chk("b_flush", 32'(b_fl), 32'(c_fl));
    chk("a_fwd",   32'(a_fwd), 32'(m_fwd));
    chk("b_fwd",   32'(b_fwd), 32'(m_fwd));
    chk("a_cnt",   32'(a_cnt), 32'(m_cnt_a));
    chk("b_cnt",   32'(b_cnt), 32'(m_cnt_b));
    chk("a_tmo",   32'(a_tmo), 32'(m_tmo_a));
    chk("b_tmo",   32'(b_tmo), 32'(m_tmo_b));
  end

  task automatic idle();
    src = '0; vld = '0; e_dest = '0; m_dest = '0; w_dest = '0;
    e_wren = 0; m_wren = 0; w_wren = 0; e_load = 0; br = 0; ic = 0; dc = 0; tp = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [4:0] s0, input logic [4:0] s1);
    src = {s1, s0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(a_st), 0);
    chk("rst_flush", 32'(a_fl), 0);
    chk("rst_fwd",   32'(a_fwd), 0);
    chk("rst_cnt",   32'(a_cnt), 0);
    chk("rst_tmo",   32'(a_tmo), 0);
    rst_n = 1'b1;
    tick();

    // Forwarding priority and r0 exclusion.
    set_src(5'd3, 5'd0); vld = 2'b11; e_dest = 5'd3; e_wren = 1; m_dest = 5'd3; m_wren = 1;
    tick();
    chk("fwd_e_over_m", 32'(a_fwd), 1);
    set_src(5'd0, 5'd0); e_dest = 5'd0; m_wren = 0;
    tick();
    chk("fwd_r0", 32'(a_fwd), 0);
    set_src(5'd7, 5'd9); e_dest = 5'd1; m_dest = 5'd7; m_wren = 1; w_dest = 5'd9; w_wren = 1;
    tick();
    chk("fwd_m_w", 32'(a_fwd), 14);

    // Load-use bubble for one cycle.
    idle();
    e_load = 1; e_wren = 1; e_dest = 5'd5; set_src(5'd0, 5'd5); vld = 2'b10;
    #2;
    chk("lu_f_stall", 32'(a_st[4]), 1);
    chk("lu_d_stall", 32'(a_st[3]), 1);
    chk("lu_e_flush", 32'(a_fl[2]), 1);
    tick();
    chk("lu_fwd_cleared", 32'(a_fwd), 0);
    e_load = 0; e_wren = 0; m_dest = 5'd5; m_wren = 1;
    #2;
    chk("lu_one_cycle", 32'(a_st), 0);
    tick();
    chk("fwd_after_lu", 32'(a_fwd), 8);

    // I-cache miss of 4 cycles with a taken branch in cycle 2.
    idle();
    ic = 1;
    #2;
    chk("ic_stall", 32'(a_st), 16);
    chk("ic_flush", 32'(a_fl), 8);
    tick();
    br = 1;
    #2;
    chk("ic_br_flush", 32'(a_fl), 12);
    tick();
    br = 0;
    tick();
    tick();
    ic = 0;
    #2;
    chk("squash_flush", 32'(a_fl), 8);
    chk("squash_nostall", 32'(a_st), 0);
    tick();
    #2;
    chk("squash_clr", 32'(a_fl), 0);
    tick();

    // D-cache wait of 3 cycles; 5 stall cycles already counted.
    dc = 1;
    #2;
    chk("dc_all_stall", 32'(a_st), 31);
    tick(); tick(); tick();
    dc = 0;
    #2;
    chk("dc_release", 32'(a_st), 0);
    chk("dc_cnt", 32'(a_cnt), 8);
    tick();

    // TPU busy: B times out at 8 cycles, A at 1024.
    for (int i = 0; i < 1024; i++) begin
      tp = 1;
      if (i == 7)    chk("tmo_b_before", 32'(b_tmo), 0);
      if (i == 8)    chk("tmo_b_set",    32'(b_tmo), 1);
      if (i == 1023) chk("tmo_a_before", 32'(a_tmo), 0);
      tick();
    end
    tp = 0;
    #2;
    chk("tmo_a_set", 32'(a_tmo), 1);
    chk("tpu_cnt_a", 32'(a_cnt), 1032);
    chk("tpu_cnt_b_sat", 32'(b_cnt), 15);
    chk("tpu_release", 32'(a_st), 0);
    tick(); tick(); tick();
    chk("tmo_a_sticky", 32'(a_tmo), 1);

    // Asynchronous reset while parked in the D-cache wait.
    dc = 1;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(a_st), 0);
    chk("arst_flush", 32'(b_fl), 0);
    chk("arst_cnt",   32'(a_cnt), 0);
    chk("arst_tmo",   32'(a_tmo), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    dc = 0;
    #2;
    chk("cnt_a_20", 32'(a_cnt), 20);
    chk("cnt_b_sat", 32'(b_cnt), 15);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
